// File: rtl/ravenoc_pkg.sv
// ----------------------------------------------------------------------------
// ravenoc_pkg
// Shared AXI4 definitions for the MPSoC interconnect and its slaves.
//   ADDR_W / DATA_W / ID_W / STRB_W : bus geometry
//   axi_burst_t   : FIXED / INCR / WRAP burst encodings
//   axi_resp_t    : OKAY / EXOKAY / SLVERR / DECERR response encodings
//   axi_sram_st_t : channel FSM states of the SRAM slave
//   s_axi_mosi_t  : AW/W/AR channels plus bready/rready (master -> slave)
//   s_axi_miso_t  : AW/W/AR readies plus B/R channels (slave -> master)
//   wrap_len_ok() : true for the burst lengths AXI allows on WRAP bursts
// ----------------------------------------------------------------------------
package ravenoc_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } axi_sram_st_t;

    typedef struct packed {
        logic [ID_W-1:0]   awid;
        logic [ADDR_W-1:0] awaddr;
        logic [7:0]        awlen;
        logic [2:0]        awsize;
        axi_burst_t        awburst;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wlast;
        logic              wvalid;
        logic              bready;
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        axi_burst_t        arburst;
        logic              arvalid;
        logic              rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        axi_resp_t         bresp;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        axi_resp_t         rresp;
        logic              rlast;
        logic              rvalid;
    } s_axi_miso_t;

    // AXI only defines WRAP for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational next-beat address calculator for one AXI channel.
//   addr      in  : address of the current beat
//   len       in  : burst length minus one (AxLEN)
//   size      in  : log2 of bytes per beat (AxSIZE)
//   burst     in  : burst type
//   next_addr out : address of the following beat
// FIXED holds the address, INCR adds one beat, WRAP increments inside the
// aligned (len+1)*(1<<size) byte window. A WRAP with an illegal length is
// advanced as INCR; flagging it is left to the caller.
// ----------------------------------------------------------------------------
module axi_burst_addr_gen
    import ravenoc_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  axi_burst_t        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_W'(1) << size;
        incr_addr = addr + step;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr = incr_addr;
        case (burst)
            FIXED: next_addr = addr;
            WRAP: begin
                // Upper bits stay in the aligned window, lower bits roll over.
                if (wrap_len_ok(len)) begin
                    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// ----------------------------------------------------------------------------
// axi_sram_slave
// AXI4 slave terminating one interconnect port with an on-chip word SRAM.
// Independent read and write FSMs, one outstanding transaction each,
// FIXED / INCR / WRAP bursts, B and R responses.
//   MEM_KB    : array size in KB (power of two, >= 4)
//   BASE_ADDR : byte base address of the window, aligned to the array size
//   clk       in  : clock, rising edge
//   arst      in  : asynchronous reset, active low
//   axi_mosi  in  : AW/W/AR channels plus bready/rready
//   axi_miso  out : AW/W/AR readies plus B/R channels
// Optional build macro AXI_SRAM_DECERR_EN: beats outside the window answer
// DECERR (writes dropped, reads return 0). Without it the address aliases
// modulo the array size.
// ----------------------------------------------------------------------------
module axi_sram_slave
    import ravenoc_pkg::*;
#(
    parameter int                MEM_KB    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h2000)
) (
    input  logic        clk,
    input  logic        arst,
    input  s_axi_mosi_t axi_mosi,
    output s_axi_miso_t axi_miso
);

    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int MEM_AW   = $clog2(MEM_KB * 1024);
    localparam int WORD_AW  = MEM_AW - ADDR_LSB;
    localparam int DEPTH    = 1 << WORD_AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write channel state
    axi_sram_st_t      w_state;
    logic              aw_ready;
    logic              w_ready;
    logic              b_valid;
    logic [ID_W-1:0]   b_id;
    axi_resp_t         b_resp;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [2:0]        w_size;
    axi_burst_t        w_burst;
    logic [7:0]        w_cnt;
    logic              w_slverr;
    logic              w_decerr;
    logic [ADDR_W-1:0] w_next;

    // Read channel state
    axi_sram_st_t      r_state;
    logic              ar_ready;
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    axi_resp_t         r_resp;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    axi_burst_t        r_burst;
    logic [7:0]        r_cnt;
    logic              r_wrap_err;
    logic [ADDR_W-1:0] r_next;

    function automatic axi_resp_t resp_code(input logic dec, input logic slv);
        if (dec) return DECERR;
        if (slv) return SLVERR;
        return OKAY;
    endfunction

    axi_burst_addr_gen u_w_addr_gen (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next)
    );

    axi_burst_addr_gen u_r_addr_gen (
        .addr      (r_addr),
        .len       (r_len),
        .size      (r_size),
        .burst     (r_burst),
        .next_addr (r_next)
    );

    // Word index and window decode. BASE_ADDR is aligned to the array size,
    // so the offset bits of the byte address are the word index directly.
    logic [WORD_AW-1:0] w_idx;
    logic [WORD_AW-1:0] ar_idx;
    logic [WORD_AW-1:0] rn_idx;
    logic               w_in;
    logic               ar_in;
    logic               rn_in;

    assign w_idx  = w_addr[MEM_AW-1:ADDR_LSB];
    assign ar_idx = axi_mosi.araddr[MEM_AW-1:ADDR_LSB];
    assign rn_idx = r_next[MEM_AW-1:ADDR_LSB];

`ifdef AXI_SRAM_DECERR_EN
    assign w_in  = (w_addr[ADDR_W-1:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW]);
    assign ar_in = (axi_mosi.araddr[ADDR_W-1:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW]);
    assign rn_in = (r_next[ADDR_W-1:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW]);
`else
    assign w_in  = 1'b1;
    assign ar_in = 1'b1;
    assign rn_in = 1'b1;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr[ADDR_W-1:MEM_AW], w_addr[ADDR_LSB-1:0],
                                axi_mosi.araddr[ADDR_W-1:MEM_AW], axi_mosi.araddr[ADDR_LSB-1:0],
                                r_next[ADDR_W-1:MEM_AW], r_next[ADDR_LSB-1:0]};

    // ------------------------------------------------------------------
    // SRAM write port: byte-lane strobes, out-of-window beats dropped
    // ------------------------------------------------------------------
    logic wr_en;
    assign wr_en = w_ready && axi_mosi.wvalid && w_in;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_mosi.wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= axi_mosi.wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    logic w_is_last;
    logic w_last_err;
    logic aw_wrap_err;

    assign w_is_last   = (w_cnt == w_len);
    // The burst ends on the beat count; wlast disagreeing with it is an error.
    assign w_last_err  = (w_is_last != axi_mosi.wlast);
    assign aw_wrap_err = (axi_mosi.awburst == WRAP) && !wrap_len_ok(axi_mosi.awlen);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            w_state  <= ST_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_id     <= '0;
            b_resp   <= OKAY;
            w_addr   <= '0;
            w_len    <= '0;
            w_size   <= '0;
            w_burst  <= FIXED;
            w_cnt    <= '0;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (aw_ready && axi_mosi.awvalid) begin
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        b_id     <= axi_mosi.awid;
                        w_addr   <= axi_mosi.awaddr;
                        w_len    <= axi_mosi.awlen;
                        w_size   <= axi_mosi.awsize;
                        w_burst  <= axi_mosi.awburst;
                        w_cnt    <= '0;
                        w_slverr <= aw_wrap_err;
                        w_decerr <= 1'b0;
                        w_state  <= ST_DATA;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (axi_mosi.wvalid) begin
                        w_addr   <= w_next;
                        w_cnt    <= w_cnt + 8'd1;
                        w_slverr <= w_slverr | w_last_err;
                        w_decerr <= w_decerr | !w_in;
                        if (w_is_last) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= resp_code(w_decerr | !w_in, w_slverr | w_last_err);
                            w_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (axi_mosi.bready) begin
                        b_valid <= 1'b0;
                        w_state <= ST_IDLE;
                    end
                end
                default: w_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. rdata is registered from the array at the handshake that
    // selects the beat, so it stays stable while rready is low and a
    // same-cycle write is seen only by later beats.
    // ------------------------------------------------------------------
    logic ar_wrap_err;
    assign ar_wrap_err = (axi_mosi.arburst == WRAP) && !wrap_len_ok(axi_mosi.arlen);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state    <= ST_IDLE;
            ar_ready   <= 1'b0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_data     <= '0;
            r_resp     <= OKAY;
            r_last     <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= FIXED;
            r_cnt      <= '0;
            r_wrap_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ar_ready && axi_mosi.arvalid) begin
                        ar_ready   <= 1'b0;
                        r_valid    <= 1'b1;
                        r_id       <= axi_mosi.arid;
                        r_addr     <= axi_mosi.araddr;
                        r_len      <= axi_mosi.arlen;
                        r_size     <= axi_mosi.arsize;
                        r_burst    <= axi_mosi.arburst;
                        r_cnt      <= '0;
                        r_wrap_err <= ar_wrap_err;
                        r_last     <= (axi_mosi.arlen == 8'd0);
                        r_data     <= ar_in ? mem[ar_idx] : '0;
                        r_resp     <= resp_code(!ar_in, ar_wrap_err);
                        r_state    <= ST_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (axi_mosi.rready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_cnt  <= r_cnt + 8'd1;
                            r_last <= ((r_cnt + 8'd1) == r_len);
                            r_data <= rn_in ? mem[rn_idx] : '0;
                            r_resp <= resp_code(!rn_in, r_wrap_err);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_miso         = '0;
        axi_miso.awready = aw_ready;
        axi_miso.wready  = w_ready;
        axi_miso.bid     = b_id;
        axi_miso.bresp   = b_resp;
        axi_miso.bvalid  = b_valid;
        axi_miso.arready = ar_ready;
        axi_miso.rid     = r_id;
        axi_miso.rdata   = r_data;
        axi_miso.rresp   = r_resp;
        axi_miso.rlast   = r_last;
        axi_miso.rvalid  = r_valid;
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed bench for axi_sram_slave (MEM_KB=8, BASE_ADDR=0x2000): a table of
// single-beat write/read vectors plus hand-written burst, error and reset
// sequences. Honours AXI_SRAM_DECERR_EN for the out-of-window case.
// ----------------------------------------------------------------------------
module tb_axi_sram_slave;
    import ravenoc_pkg::*;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;

    always #5 clk = ~clk;

    axi_sram_slave #(
        .MEM_KB    (8),
        .BASE_ADDR (32'h2000)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .axi_mosi (mosi),
        .axi_miso (miso)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wbuf  [16];
    logic [3:0]  sbuf  [16];
    logic [31:0] rbuf  [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];
    logic [3:0]  got_bid;
    logic [1:0]  got_bresp;
    logic [3:0]  got_rid;
    logic        first_rvalid;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input axi_burst_t burst, input int last_beat);
        int  n;
        bit  ok;
        mosi.awid    = id;
        mosi.awaddr  = addr;
        mosi.awlen   = len;
        mosi.awsize  = 3'd2;
        mosi.awburst = burst;
        mosi.awvalid = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); n++;
            if (miso.awready) ok = 1;
        end
        @(posedge clk); #1;
        mosi.awvalid = 1'b0;
        if (!ok) check("aw_handshake", 32'd0, 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            mosi.wdata  = wbuf[b];
            mosi.wstrb  = sbuf[b];
            mosi.wlast  = (b == last_beat);
            mosi.wvalid = 1'b1;
            ok = 0; n = 0;
            while (!ok && n < 50) begin
                @(negedge clk); n++;
                if (miso.wready) ok = 1;
            end
            @(posedge clk); #1;
            if (!ok) check("w_handshake", 32'd0, 32'd1);
        end
        mosi.wvalid = 1'b0;
        mosi.wlast  = 1'b0;
        mosi.bready = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); n++;
            if (miso.bvalid) begin
                ok = 1;
                got_bid   = miso.bid;
                got_bresp = miso.bresp;
            end
        end
        @(posedge clk); #1;
        mosi.bready = 1'b0;
        if (!ok) check("b_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input axi_burst_t burst, input bit toggle);
        int          n;
        int          beat;
        bit          ok;
        bit          held_v;
        logic [31:0] held;
        mosi.arid    = id;
        mosi.araddr  = addr;
        mosi.arlen   = len;
        mosi.arsize  = 3'd2;
        mosi.arburst = burst;
        mosi.arvalid = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); n++;
            if (miso.arready) ok = 1;
        end
        @(posedge clk); #1;
        mosi.arvalid = 1'b0;
        if (!ok) check("ar_handshake", 32'd0, 32'd1);
        mosi.rready = !toggle;
        beat = 0; n = 0; held_v = 0; held = '0;
        while (beat <= int'(len) && n < 200) begin
            @(negedge clk); n++;
            if (n == 1) first_rvalid = miso.rvalid;
            if (miso.rvalid) begin
                if (held_v) begin
                    check("r_stall_hold", miso.rdata, held);
                    held_v = 0;
                end
                if (mosi.rready) begin
                    rbuf[beat]  = miso.rdata;
                    rrbuf[beat] = miso.rresp;
                    rlbuf[beat] = miso.rlast;
                    got_rid     = miso.rid;
                    beat++;
                end else begin
                    held   = miso.rdata;
                    held_v = 1;
                end
            end
            @(posedge clk); #1;
            if (toggle) mosi.rready = !mosi.rready;
        end
        mosi.rready = 1'b0;
        if (beat <= int'(len)) check("r_timeout", 32'(beat), 32'(len) + 32'd1);
    endtask

    initial begin
        int  n;
        int  beat;
        bit  done;

        vecs[0] = '{32'h2004, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[1] = '{32'h2040, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
        vecs[2] = '{32'h2040, 32'hAABBCCDD, 4'h5, 32'hFFBBFFDD};
        vecs[3] = '{32'h2044, 32'h12345678, 4'hF, 32'h12345678};
        vecs[4] = '{32'h2044, 32'h00000000, 4'h8, 32'h00345678};
        vecs[5] = '{32'h2048, 32'h01020304, 4'hF, 32'h01020304};
        vecs[6] = '{32'h2048, 32'hFFFFFFFF, 4'h2, 32'h0102FF04};
        vecs[7] = '{32'h3FFC, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};

        mosi = '0;
        for (int i = 0; i < 16; i++) sbuf[i] = 4'hF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(miso.awready), 32'd0);
        check("rst_arready", 32'(miso.arready), 32'd0);
        check("rst_wready",  32'(miso.wready),  32'd0);
        check("rst_bvalid",  32'(miso.bvalid),  32'd0);
        check("rst_rvalid",  32'(miso.rvalid),  32'd0);
        check("rst_rdata",   miso.rdata,        32'd0);
        check("rst_bresp",   32'(miso.bresp),   32'd0);
        check("rst_rid",     32'(miso.rid),     32'd0);
        @(negedge clk);
        arst = 1'b1;
        #1;
        check("rel_awready_pre", 32'(miso.awready), 32'd0);
        @(posedge clk); #1;
        check("rel_awready", 32'(miso.awready), 32'd1);
        check("rel_arready", 32'(miso.arready), 32'd1);

        // Table: single-beat write then read back
        for (int i = 0; i < 8; i++) begin
            wbuf[0] = vecs[i].wdata;
            sbuf[0] = vecs[i].wstrb;
            do_write(4'(i), vecs[i].addr, 8'd0, INCR, 0);
            check($sformatf("vec%0d_bid", i), 32'(got_bid), 32'(i));
            check($sformatf("vec%0d_bresp", i), 32'(got_bresp), 32'(OKAY));
            do_read(4'(i + 8), vecs[i].addr, 8'd0, INCR, 0);
            check($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), 32'(rrbuf[0]), 32'(OKAY));
            check($sformatf("vec%0d_rlast", i), 32'(rlbuf[0]), 32'd1);
            check($sformatf("vec%0d_rid", i), 32'(got_rid), 32'(i + 8));
            check($sformatf("vec%0d_rlatency", i), 32'(first_rvalid), 32'd1);
        end
        sbuf[0] = 4'hF;

        // INCR burst, read back with rready toggling
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        do_write(4'd3, 32'h2010, 8'd3, INCR, 3);
        check("incr_bresp", 32'(got_bresp), 32'(OKAY));
        do_read(4'd5, 32'h2010, 8'd3, INCR, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("incr_rdata%0d", k), rbuf[k], 32'h11 * 32'(k + 1));
            check($sformatf("incr_rlast%0d", k), 32'(rlbuf[k]), 32'(k == 3));
        end

        // WRAP len=3 from 0x2028: beats land at 28, 2C, 20, 24
        wbuf[0] = 32'hA1; wbuf[1] = 32'hA2; wbuf[2] = 32'hA3; wbuf[3] = 32'hA4;
        do_write(4'd2, 32'h2028, 8'd3, WRAP, 3);
        check("wrap_bresp", 32'(got_bresp), 32'(OKAY));
        do_read(4'd1, 32'h2020, 8'd0, INCR, 0);
        check("wrap_word20", rbuf[0], 32'hA3);
        do_read(4'd1, 32'h202C, 8'd0, INCR, 0);
        check("wrap_word2c", rbuf[0], 32'hA2);
        do_read(4'd1, 32'h2028, 8'd3, WRAP, 0);
        check("wrap_rd0", rbuf[0], 32'hA1);
        check("wrap_rd2", rbuf[2], 32'hA3);
        check("wrap_rd3", rbuf[3], 32'hA4);
        check("wrap_rresp", 32'(rrbuf[3]), 32'(OKAY));

        // WRAP with illegal len=2: processed as INCR, SLVERR
        wbuf[0] = 32'hB1; wbuf[1] = 32'hB2; wbuf[2] = 32'hB3;
        do_write(4'd4, 32'h2080, 8'd2, WRAP, 2);
        check("wrap2_bresp", 32'(got_bresp), 32'(SLVERR));
        do_read(4'd4, 32'h2080, 8'd2, INCR, 0);
        check("wrap2_incr_rd2", rbuf[2], 32'hB3);
        check("wrap2_incr_rresp", 32'(rrbuf[2]), 32'(OKAY));
        do_read(4'd4, 32'h2080, 8'd2, WRAP, 0);
        check("wrap2_rd1", rbuf[1], 32'hB2);
        check("wrap2_rresp", 32'(rrbuf[1]), 32'(SLVERR));

        // Early wlast: data still written, SLVERR
        wbuf[0] = 32'hC1; wbuf[1] = 32'hC2;
        do_write(4'd6, 32'h20C0, 8'd1, INCR, 0);
        check("early_wlast_bresp", 32'(got_bresp), 32'(SLVERR));
        do_read(4'd6, 32'h20C0, 8'd1, INCR, 0);
        check("early_wlast_rd1", rbuf[1], 32'hC2);
        // Missing wlast
        do_write(4'd7, 32'h20D0, 8'd1, INCR, 99);
        check("no_wlast_bresp", 32'(got_bresp), 32'(SLVERR));
        // FIXED burst: both beats hit the same word
        wbuf[0] = 32'hD1; wbuf[1] = 32'hD2;
        do_write(4'd8, 32'h20E0, 8'd1, FIXED, 1);
        check("fixed_bresp", 32'(got_bresp), 32'(OKAY));
        do_read(4'd8, 32'h20E0, 8'd0, INCR, 0);
        check("fixed_rdata", rbuf[0], 32'hD2);

        // Out-of-window address 0x4000
        wbuf[0] = 32'h13579BDF;
        do_write(4'd1, 32'h2000, 8'd0, INCR, 0);
        wbuf[0] = 32'h77777777;
        do_write(4'd1, 32'h4000, 8'd0, INCR, 0);
`ifdef AXI_SRAM_DECERR_EN
        check("oow_bresp", 32'(got_bresp), 32'(DECERR));
        do_read(4'd1, 32'h4000, 8'd0, INCR, 0);
        check("oow_rdata", rbuf[0], 32'd0);
        check("oow_rresp", 32'(rrbuf[0]), 32'(DECERR));
        do_read(4'd1, 32'h2000, 8'd0, INCR, 0);
        check("oow_dropped", rbuf[0], 32'h13579BDF);
`else
        check("alias_bresp", 32'(got_bresp), 32'(OKAY));
        do_read(4'd1, 32'h2000, 8'd0, INCR, 0);
        check("alias_rdata", rbuf[0], 32'h77777777);
        check("alias_rresp", 32'(rrbuf[0]), 32'(OKAY));
`endif

        // Reset during beat 2 of an 8-beat read
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hE0 + 32'(k);
        do_write(4'd9, 32'h2100, 8'd7, INCR, 7);
        check("rst8_bresp", 32'(got_bresp), 32'(OKAY));
        mosi.arid    = 4'd6;
        mosi.araddr  = 32'h2100;
        mosi.arlen   = 8'd7;
        mosi.arsize  = 3'd2;
        mosi.arburst = INCR;
        mosi.arvalid = 1'b1;
        done = 0; n = 0;
        while (!done && n < 50) begin
            @(negedge clk); n++;
            if (miso.arready) done = 1;
        end
        @(posedge clk); #1;
        mosi.arvalid = 1'b0;
        mosi.rready  = 1'b1;
        done = 0; n = 0; beat = 0;
        while (!done && n < 50) begin
            @(negedge clk); n++;
            if (miso.rvalid) begin
                if (beat == 1) begin
                    check("rst8_beat2_data", miso.rdata, 32'hE1);
                    arst = 1'b0;
                    #1;
                    check("rst8_rvalid_drop", 32'(miso.rvalid), 32'd0);
                    check("rst8_arready_low", 32'(miso.arready), 32'd0);
                    done = 1;
                end else begin
                    beat++;
                end
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        if (!done) check("rst8_timeout", 32'd0, 32'd1);
        mosi.rready = 1'b0;
        repeat (2) @(negedge clk);
        arst = 1'b1;
        #1;
        check("rst8_arready_pre", 32'(miso.arready), 32'd0);
        @(posedge clk); #1;
        check("rst8_arready_post", 32'(miso.arready), 32'd1);
        do_read(4'd3, 32'h2100, 8'd7, INCR, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rst8_rd%0d", k), rbuf[k], 32'hE0 + 32'(k));
        end
        check("rst8_rlast", 32'(rlbuf[7]), 32'd1);
        check("rst8_rid", 32'(got_rid), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
